nx_fifo_pop_stage: RTL and testbench
====================================

// Module: nx_fifo_pop_stage
// PURPOSE
//  Read-side companion for nx_fifo: drains a show-ahead FIFO (combinational head on rdata,
//  empty flag) and re-presents words as a registered valid/ready stream. A 2-entry skid
//  buffer keeps full throughput under consumer backpressure. The block never pops an empty
//  FIFO. Sits between any nx_fifo instance and a downstream pipeline stage.
// PARAMETERS
//  WIDTH   71  data word width; bit [WIDTH-1] is the parity bit when NX_FIFO_POP_PARITY_EN set
//  CNT_W   16  width of the popped-word counter
// PORTS
//  clk          in   1        single clock; all state on posedge
//  rst          in   1        asynchronous, active-high reset
//  fifo_empty   in   1        FIFO empty flag
//  fifo_rdata   in   WIDTH    FIFO head word, valid while !fifo_empty
//  fifo_ren     out  1        pop strobe to FIFO (combinational)
//  fifo_clear   out  1        clear strobe to FIFO (= flush)
//  flush        in   1        synchronous drop of all buffered and queued data
//  out_valid    out  1        output word valid (registered)
//  out_ready    in   1        downstream accept
//  out_data     out  WIDTH    output word (registered)
//  held         out  2        words held locally: 0..2
//  pop_count    out  CNT_W    total words popped, wraps modulo 2^CNT_W
//  parity_err   out  1        sticky parity error (0 when feature compiled out)
// BEHAVIOUR
//  - Reset (async assert): held=0, out_valid=0, out_data=0, pop_count=0, parity_err=0.
//    fifo_ren=0 while rst is high.
//  - pop    = fifo_ren = !rst && !fifo_empty && !flush && (held < 2).
//  - accept = out_valid && out_ready.
//  - held_next = held + pop - accept. held never exceeds 2. The three states are
//    EMPTY(0), ONE(1) and TWO(2).
//  - Latency: a word popped in cycle N appears on out_data with out_valid=1 in N+1 if the
//    buffer was empty or accept occurred in N. Otherwise it is stored in the skid slot.
//  - Order is strict FIFO. The skid slot moves to the output register on the cycle after
//    accept.
//  - out_valid = (held != 0). out_data is held stable while out_valid && !out_ready.
//  - Steady state held=1 with out_ready=1 and a non-empty FIFO gives 1 word/cycle.
//  - In TWO, pop=0 regardless of fifo_empty. This is the backpressure path to the FIFO.
//  - flush=1: fifo_clear=1 in the same cycle, pop=0, and the accept in that cycle is
//    ignored. The next cycle gives held=0 and out_valid=0. out_data is left unchanged.
//    pop_count and parity_err are not affected.
//  - pop_count increments by 1 on every pop and wraps from all-ones to 0.
//  - Simultaneous pop and accept in ONE: held stays 1, and the output register loads the
//    new word.
// CONFIGURATION
//  NX_FIFO_POP_PARITY_EN defined:
//    - Each popped word is checked for even parity over fifo_rdata[WIDTH-1:0].
//    - On a mismatch, parity_err is set in the cycle after the pop. It stays set until rst.
//    - Data still passes through unmodified.
//  NX_FIFO_POP_PARITY_EN undefined: parity_err is tied to 0 and no check logic exists.
// TESTING
//  1 Reset: assert rst mid-stream with held=2 -> out_valid=0, held=0, fifo_ren=0
//    immediately, and pop_count=0.
//  2 Streaming: FIFO holds 0x01..0x08, out_ready=1 -> fifo_ren high 8 cycles.
//    out_data=0x01..0x08 on consecutive cycles, one cycle later; pop_count=8.
//  3 Backpressure: 4 words queued, out_ready=0 -> exactly 2 pops, held=2, out_data=word0
//    stable. Then out_ready=1 -> words 0..3 in order with no gap.
//  4 Empty guard: fifo_empty=1 throughout with out_ready toggling -> fifo_ren never 1,
//    out_valid=0.
//  5 Flush: held=2 and FIFO non-empty, pulse flush 1 cycle -> fifo_clear=1 that cycle, no
//    pop, then held=0 and out_valid=0.
//  6 Parity (macro on): pop word 71'h1 (odd parity) -> parity_err=1 next cycle and still 1
//    after 10 good words. Macro off -> parity_err stays 0.

Source files
------------

// File: rtl/nx_fifo_pop_stage_if.sv
// Handshake bundle for nx_fifo_pop_stage: show-ahead FIFO read side plus the valid/ready output stream.
// master = the pop stage, slave = the FIFO/consumer environment.
interface nx_fifo_pop_stage_if #(
  parameter int WIDTH = 71
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_ren;
  logic             fifo_clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    input  fifo_empty, fifo_rdata, out_ready,
    output fifo_ren, fifo_clear, out_valid, out_data
  );

  modport slave (
    output fifo_empty, fifo_rdata, out_ready,
    input  fifo_ren, fifo_clear, out_valid, out_data
  );
endinterface

// File: rtl/nx_fifo_pop_stage.sv
// Drains a show-ahead nx_fifo into a registered valid/ready stream through a 2-entry skid buffer.
// Optional sticky even-parity check on popped words when NX_FIFO_POP_PARITY_EN is defined.
module nx_fifo_pop_stage #(
  parameter int WIDTH = 71,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  nx_fifo_pop_stage_if.master  bus,
  input  logic                 flush,
  output logic [1:0]           held,
  output logic [CNT_W-1:0]     pop_count,
  output logic                 parity_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             pop;
  logic             accept;

  // A full skid buffer is the backpressure path: no pop in TWO whatever the FIFO says.
  assign pop    = !rst && !bus.fifo_empty && !flush && (state_q != TWO);
  assign accept = (state_q != EMPTY) && bus.out_ready && !flush;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (pop) begin
            state_d = ONE;
            out_d   = bus.fifo_rdata;
          end
        end
        ONE: begin
          if (pop && accept) begin
            out_d = bus.fifo_rdata;
          end else if (pop) begin
            state_d = TWO;
            skid_d  = bus.fifo_rdata;
          end else if (accept) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (accept) begin
            state_d = ONE;
            out_d   = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_count <= '0;
    end else if (pop) begin
      pop_count <= pop_count + 1'b1;
    end
  end

`ifdef NX_FIFO_POP_PARITY_EN
  logic perr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else if (pop && (^bus.fifo_rdata)) begin
      perr_q <= 1'b1;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign bus.fifo_ren   = pop;
  assign bus.fifo_clear = flush;
  assign bus.out_valid  = (state_q != EMPTY);
  assign bus.out_data   = out_q;
  assign held           = state_q;

endmodule

// File: tb/tb_nx_fifo_pop_stage.sv
// Self-checking bench for nx_fifo_pop_stage: directed scenarios plus randomized traffic
// compared against a queue-based model of the FIFO and the two-word holding stage.
module tb_nx_fifo_pop_stage;

  localparam int W  = 71;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [1:0]    held;
  logic [CW-1:0] pop_count;
  logic          parity_err;

  nx_fifo_pop_stage_if #(.WIDTH(W)) bus ();

  nx_fifo_pop_stage #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flush      (flush),
    .held       (held),
    .pop_count  (pop_count),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Reference model: fq is the FIFO contents, sq the words owned by the stage (head = on output).
  logic [W-1:0]  fq[$];
  logic [W-1:0]  sq[$];
  logic [CW-1:0] exp_cnt;
  logic          exp_perr;
  logic [W-1:0]  exp_last;
  logic          exp_pop;
  logic          cur_rdy;
  logic          cur_fl;

  int errors = 0;
  int checks = 0;

`ifdef NX_FIFO_POP_PARITY_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  function automatic logic [W-1:0] rand_word();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] even_word();
    logic [W-1:0] w;
    w = rand_word();
    if (^w) w[W-1] = ~w[W-1];
    return w;
  endfunction

  task automatic model_reset();
    sq.delete();
    exp_cnt  = '0;
    exp_perr = 1'b0;
    exp_last = '0;
  endtask

  // Called just after a negedge: present inputs and compute the expected pop.
  task automatic drive(input logic rdy, input logic fl);
    cur_rdy        = rdy;
    cur_fl         = fl;
    bus.out_ready  = rdy;
    flush          = fl;
    bus.fifo_empty = (fq.size() == 0);
    if (fq.size() != 0) bus.fifo_rdata = fq[0];
    else                bus.fifo_rdata = rand_word();
    exp_pop = !rst && !fl && (fq.size() != 0) && (sq.size() < 2);
    #1;
  endtask

  task automatic advance();
    logic [W-1:0] w;
    @(posedge clk);
    if (!rst) begin
      if (cur_fl) begin
        fq.delete();
        sq.delete();
      end else begin
        if (sq.size() != 0 && cur_rdy) w = sq.pop_front();
        if (exp_pop) begin
          w = fq.pop_front();
          sq.push_back(w);
          exp_cnt = exp_cnt + 1'b1;
          if (PAR_ON && (^w)) exp_perr = 1'b1;
        end
      end
      if (sq.size() != 0) exp_last = sq[0];
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL por_valid: got %0b exp 0", bus.out_valid); end
    checks++; if (held !== 2'd0) begin errors++; $display("FAIL por_held: got %0d exp 0", held); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL por_data: got %h exp 0", bus.out_data); end
    checks++; if (pop_count !== '0) begin errors++; $display("FAIL por_cnt: got %0d exp 0", pop_count); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL por_perr: got %0b exp 0", parity_err); end
    advance();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) fq.push_back(even_word());
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0);
      advance();
    end
    drive(1'b0, 1'b0);
    checks++; if (held !== 2'd2) begin errors++; $display("FAIL rst_pre_held: got %0d exp 2", held); end
    #1 rst = 1'b1;
    model_reset();
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b exp 0", bus.out_valid); end
    checks++; if (held !== 2'd0) begin errors++; $display("FAIL rst_held: got %0d exp 0", held); end
    checks++; if (bus.fifo_ren !== 1'b0) begin errors++; $display("FAIL rst_ren: got %0b exp 0", bus.fifo_ren); end
    checks++; if (pop_count !== '0) begin errors++; $display("FAIL rst_cnt: got %0d exp 0", pop_count); end
    @(negedge clk);
    rst = 1'b0;
    fq.delete();
  endtask

  task automatic test_streaming();
    logic [W-1:0] got[$];
    int ren_cnt = 0;
    int first = -1;
    int last  = -1;
    logic [W-1:0] wv;
    for (int i = 1; i <= 8; i++) begin
      wv = W'(i);
      fq.push_back(wv);
    end
    for (int c = 0; c < 11; c++) begin
      drive(1'b1, 1'b0);
      checks++; if (bus.fifo_ren !== exp_pop) begin errors++; $display("FAIL str_ren c%0d: got %0b exp %0b", c, bus.fifo_ren, exp_pop); end
      if (bus.fifo_ren === 1'b1) ren_cnt++;
      if (bus.out_valid === 1'b1) begin
        got.push_back(bus.out_data);
        if (first < 0) first = c;
        last = c;
      end
      advance();
    end
    checks++; if (ren_cnt != 8) begin errors++; $display("FAIL str_ren_count: got %0d exp 8", ren_cnt); end
    checks++; if (got.size() != 8) begin errors++; $display("FAIL str_words: got %0d exp 8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++; if (got[i] !== W'(i + 1)) begin errors++; $display("FAIL str_data%0d: got %h exp %h", i, got[i], W'(i + 1)); end
    end
    checks++; if (first != 1 || last != 8) begin errors++; $display("FAIL str_timing: got first=%0d last=%0d exp 1 8", first, last); end
    checks++; if (pop_count !== 16'd8) begin errors++; $display("FAIL str_cnt: got %0d exp 8", pop_count); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] wv[4];
    logic [W-1:0] got[$];
    int ren_cnt = 0;
    int first = -1;
    int last  = -1;
    for (int i = 0; i < 4; i++) begin
      wv[i] = even_word();
      fq.push_back(wv[i]);
    end
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0);
      if (bus.fifo_ren === 1'b1) ren_cnt++;
      checks++; if (bus.out_data !== exp_last) begin errors++; $display("FAIL bp_hold_data c%0d: got %h exp %h", c, bus.out_data, exp_last); end
      advance();
    end
    drive(1'b0, 1'b0);
    checks++; if (ren_cnt != 2) begin errors++; $display("FAIL bp_pops: got %0d exp 2", ren_cnt); end
    checks++; if (held !== 2'd2) begin errors++; $display("FAIL bp_held: got %0d exp 2", held); end
    checks++; if (bus.out_data !== wv[0]) begin errors++; $display("FAIL bp_word0: got %h exp %h", bus.out_data, wv[0]); end
    checks++; if (bus.fifo_ren !== 1'b0) begin errors++; $display("FAIL bp_ren_full: got %0b exp 0", bus.fifo_ren); end
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0);
      if (bus.out_valid === 1'b1) begin
        got.push_back(bus.out_data);
        if (first < 0) first = c;
        last = c;
      end
      advance();
    end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL bp_words: got %0d exp 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== wv[i]) begin errors++; $display("FAIL bp_order%0d: got %h exp %h", i, got[i], wv[i]); end
    end
    checks++; if (last - first != 3) begin errors++; $display("FAIL bp_gap: got span %0d exp 3", last - first); end
  endtask

  task automatic test_empty_guard();
    for (int c = 0; c < 8; c++) begin
      drive(c[0], 1'b0);
      checks++; if (bus.fifo_ren !== 1'b0) begin errors++; $display("FAIL eg_ren c%0d: got %0b exp 0", c, bus.fifo_ren); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL eg_valid c%0d: got %0b exp 0", c, bus.out_valid); end
      advance();
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] saved;
    for (int i = 0; i < 4; i++) fq.push_back(even_word());
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0);
      advance();
    end
    saved = exp_last;
    drive(1'b1, 1'b1);
    checks++; if (held !== 2'd2) begin errors++; $display("FAIL fl_pre_held: got %0d exp 2", held); end
    checks++; if (bus.fifo_clear !== 1'b1) begin errors++; $display("FAIL fl_clear: got %0b exp 1", bus.fifo_clear); end
    checks++; if (bus.fifo_ren !== 1'b0) begin errors++; $display("FAIL fl_ren: got %0b exp 0", bus.fifo_ren); end
    advance();
    drive(1'b1, 1'b0);
    checks++; if (held !== 2'd0) begin errors++; $display("FAIL fl_held: got %0d exp 0", held); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %0b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== saved) begin errors++; $display("FAIL fl_data: got %h exp %h", bus.out_data, saved); end
    checks++; if (bus.fifo_clear !== 1'b0) begin errors++; $display("FAIL fl_clear_off: got %0b exp 0", bus.fifo_clear); end
    checks++; if (pop_count !== exp_cnt) begin errors++; $display("FAIL fl_cnt: got %0d exp %0d", pop_count, exp_cnt); end
    advance();
  endtask

  task automatic test_random();
    logic rdy;
    logic fl;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) != 0 && fq.size() < 8) fq.push_back(rand_word());
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 29) == 0);
      drive(rdy, fl);
      checks++; if (bus.fifo_ren !== exp_pop) begin errors++; $display("FAIL rnd_ren c%0d: got %0b exp %0b", c, bus.fifo_ren, exp_pop); end
      checks++; if (bus.fifo_clear !== fl) begin errors++; $display("FAIL rnd_clear c%0d: got %0b exp %0b", c, bus.fifo_clear, fl); end
      checks++; if (held !== 2'(sq.size())) begin errors++; $display("FAIL rnd_held c%0d: got %0d exp %0d", c, held, sq.size()); end
      checks++; if (bus.out_valid !== (sq.size() != 0)) begin errors++; $display("FAIL rnd_valid c%0d: got %0b exp %0b", c, bus.out_valid, sq.size() != 0); end
      checks++; if (bus.out_data !== exp_last) begin errors++; $display("FAIL rnd_data c%0d: got %h exp %h", c, bus.out_data, exp_last); end
      checks++; if (pop_count !== exp_cnt) begin errors++; $display("FAIL rnd_cnt c%0d: got %0d exp %0d", c, pop_count, exp_cnt); end
      checks++; if (parity_err !== exp_perr) begin errors++; $display("FAIL rnd_perr c%0d: got %0b exp %0b", c, parity_err, exp_perr); end
      advance();
    end
    drive(1'b0, 1'b1);
    advance();
  endtask

  task automatic test_parity();
    logic [W-1:0] bad;
    bad = '0;
    bad[0] = 1'b1;
    rst = 1'b1;
    model_reset();
    fq.delete();
    @(negedge clk);
    rst = 1'b0;
    fq.push_back(bad);
    for (int i = 0; i < 10; i++) fq.push_back(even_word());
    drive(1'b1, 1'b0);
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_before: got %0b exp 0", parity_err); end
    advance();
    drive(1'b1, 1'b0);
    checks++; if (parity_err !== PAR_ON) begin errors++; $display("FAIL par_set: got %0b exp %0b", parity_err, PAR_ON); end
    checks++; if (bus.out_data !== bad) begin errors++; $display("FAIL par_passthru: got %h exp %h", bus.out_data, bad); end
    for (int c = 0; c < 12; c++) begin
      advance();
      drive(1'b1, 1'b0);
    end
    checks++; if (parity_err !== PAR_ON) begin errors++; $display("FAIL par_sticky: got %0b exp %0b", parity_err, PAR_ON); end
    checks++; if (parity_err !== exp_perr) begin errors++; $display("FAIL par_model: got %0b exp %0b", parity_err, exp_perr); end
    checks++; if (pop_count !== 16'd11) begin errors++; $display("FAIL par_cnt: got %0d exp 11", pop_count); end
    advance();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    bus.out_ready  = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = '0;
    cur_rdy        = 1'b0;
    cur_fl         = 1'b0;
    exp_pop        = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_guard();
    test_flush();
    test_random();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
